sample_log_pipe_out: RTL and testbench

Captures the simulation outputs (muscle force and spindle Ia rate, both IEEE-754 single) once per `sim_clk` period. Packs each capture into a 4-word frame in an on-chip FIFO. Streams the FIFO to the host through a block-throttled pipe-out endpoint in the `ti_clk` domain. It sits downstream of the muscle and spindle stages and replaces per-sample wire-out polling.

---
 rtl/sample_log_pipe_out_if.sv | 10 +
 rtl/sample_log_pipe_out.sv | 210 +++++++++++++++++++++
 tb/tb_sample_log_pipe_out.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_log_pipe_out_if.sv
// Pipe-out endpoint bundle between the sample logger (slave) and the host
// interface (master).
interface sample_log_pipe_out_if;
    logic        pipe_read;
    logic [15:0] pipe_data;
    logic        pipe_ready;

    modport master (output pipe_read, input pipe_data, input pipe_ready);
    modport slave  (input pipe_read, output pipe_data, output pipe_ready);
endinterface

// File: rtl/sample_log_pipe_out.sv
// Captures force / Ia-rate words once per sim_clk period, packs each capture
// as four 16-bit words into a FIFO and streams them out through a block-throttled pipe.
module sample_log_pipe_out #(
    parameter int DEPTH_LOG2  = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  reset_global,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  sample_clk,
    input  logic [31:0]           ch0,
    input  logic [31:0]           ch1,
    sample_log_pipe_out_if.slave  pipe,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           frames_dropped
);

    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] MAX_FILL  = CNT_W'(DEPTH - 4);
    localparam logic [CNT_W-1:0] BLOCK_CNT = CNT_W'(BLOCK_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W0,
        S_W1,
        S_W2,
        S_W3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         sync_q;
    logic [63:0]        snap_q, snap_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic [15:0]        dropped_q, dropped_d;
    logic [15:0]        pipe_data_q, pipe_data_d;
    logic               pipe_ready_q;
    logic [15:0]        mem [DEPTH];
    logic [15:0]        mem_rd;

    logic tick;
    logic accept;
    logic drop;
    logic wr_en;
    logic rd_en;
    logic [15:0] wr_word;

    // Bits 1:0 synchronize sample_clk; bit 2 is the previous synchronized level.
    assign tick   = sync_q[2] & ~sync_q[1];
    assign mem_rd = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            sync_q <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value of its neighbour; blocking here would collapse the chain.
            sync_q <= {sync_q[1:0], sample_clk};
        end
    end

    // Frame writer: free space is checked once per tick, for all four words.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case/if tree can leave a value unassigned and infer a latch.
        state_d = state_q;
        snap_d  = snap_q;
        wr_en   = 1'b0;
        wr_word = 16'h0000;
        accept  = 1'b0;
        drop    = 1'b0;

        if (tick && enable) begin
            if (state_q == S_IDLE && count_q <= MAX_FILL) begin
                accept = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    snap_d  = {ch1, ch0};
                    state_d = S_W0;
                end
            end
            S_W0: begin
                wr_en   = 1'b1;
                wr_word = snap_q[15:0];
                state_d = S_W1;
            end
            S_W1: begin
                wr_en   = 1'b1;
                wr_word = snap_q[31:16];
                state_d = S_W2;
            end
            S_W2: begin
                wr_en   = 1'b1;
                wr_word = snap_q[47:32];
                state_d = S_W3;
            end
            S_W3: begin
                wr_en   = 1'b1;
                wr_word = snap_q[63:48];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d = S_IDLE;
            wr_en   = 1'b0;
            drop    = 1'b0;
        end
    end

    // FIFO pointers, occupancy, read port and sticky status.
    always_comb begin
        rd_en       = pipe.pipe_read && (count_q != '0) && !clear;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | drop;
        underflow_d = underflow_q;
        dropped_d   = dropped_q;
        pipe_data_d = pipe_data_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            pipe_data_d = mem_rd;
        end else if (pipe.pipe_read) begin
            pipe_data_d = 16'h0000;
            underflow_d = 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop && dropped_q != 16'hFFFF) begin
            dropped_d = dropped_q + 16'd1;
        end

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            dropped_d   = 16'h0000;
            pipe_data_d = pipe_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            state_q      <= S_IDLE;
            snap_q       <= 64'h0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            dropped_q    <= 16'h0000;
            pipe_data_q  <= 16'h0000;
            pipe_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            dropped_q    <= dropped_d;
            pipe_data_q  <= pipe_data_d;
            pipe_ready_q <= (count_q >= BLOCK_CNT);
        end
    end

    // NOTE: the storage array has no reset; its contents are only ever read
    // behind word_count, so clearing it would buy nothing but a reset tree.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    assign pipe.pipe_data  = pipe_data_q;
    assign pipe.pipe_ready = pipe_ready_q;
    assign word_count      = count_q;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;
    assign frames_dropped  = dropped_q;

endmodule

// File: tb/tb_sample_log_pipe_out.sv
// Bench for sample_log_pipe_out: a default-size instance and a 16-word instance
// share the sim-side stimulus; expected words come from a queue model of frames.
module tb_sample_log_pipe_out;

    logic        clk = 1'b0;
    logic        reset_global;
    logic        clear;
    logic        enable;
    logic        sample_clk;
    logic [31:0] ch0;
    logic [31:0] ch1;

    always #5 clk = ~clk;

    sample_log_pipe_out_if if_big ();
    sample_log_pipe_out_if if_small ();

    logic [10:0] wc_big;
    logic        ovf_big, unf_big;
    logic [15:0] fd_big;
    logic [4:0]  wc_small;
    logic        ovf_small, unf_small;
    logic [15:0] fd_small;

    sample_log_pipe_out #(.DEPTH_LOG2(10), .BLOCK_WORDS(256)) dut_big (
        .clk            (clk),
        .reset_global   (reset_global),
        .clear          (clear),
        .enable         (enable),
        .sample_clk     (sample_clk),
        .ch0            (ch0),
        .ch1            (ch1),
        .pipe           (if_big),
        .word_count     (wc_big),
        .overflow       (ovf_big),
        .underflow      (unf_big),
        .frames_dropped (fd_big)
    );

    sample_log_pipe_out #(.DEPTH_LOG2(4), .BLOCK_WORDS(8)) dut_small (
        .clk            (clk),
        .reset_global   (reset_global),
        .clear          (clear),
        .enable         (enable),
        .sample_clk     (sample_clk),
        .ch0            (ch0),
        .ch1            (ch1),
        .pipe           (if_small),
        .word_count     (wc_small),
        .overflow       (ovf_small),
        .underflow      (unf_small),
        .frames_dropped (fd_small)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];

    // Reference model: a capture becomes four words, low half of ch0 first.
    task automatic push_model(input logic [31:0] c0, input logic [31:0] c1);
        exp_q.push_back(c0[15:0]);
        exp_q.push_back(c0[31:16]);
        exp_q.push_back(c1[15:0]);
        exp_q.push_back(c1[31:16]);
    endtask

    task automatic start_frame(input logic [31:0] c0, input logic [31:0] c1, input int hi);
        @(negedge clk);
        ch0        = c0;
        ch1        = c1;
        sample_clk = 1'b1;
        repeat (hi) @(negedge clk);
        sample_clk = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] c0, input logic [31:0] c1);
        start_frame(c0, c1, 10);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_q.delete();
    endtask

    task automatic read_big(output logic [15:0] d);
        @(negedge clk);
        if_big.pipe_read = 1'b1;
        @(negedge clk);
        if_big.pipe_read = 1'b0;
        d = if_big.pipe_data;
    endtask

    task automatic read_small(output logic [15:0] d);
        @(negedge clk);
        if_small.pipe_read = 1'b1;
        @(negedge clk);
        if_small.pipe_read = 1'b0;
        d = if_small.pipe_data;
    endtask

    task automatic test_reset();
        reset_global       = 1'b1;
        clear              = 1'b0;
        enable             = 1'b1;
        sample_clk         = 1'b0;
        ch0                = 32'h0;
        ch1                = 32'h0;
        if_big.pipe_read   = 1'b0;
        if_small.pipe_read = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({wc_big, ovf_big, unf_big, fd_big, if_big.pipe_data, if_big.pipe_ready} !== '0) begin
            $display("FAIL reset_big: got count=%0d ovf=%b unf=%b drop=%0d data=%h ready=%b, want all zero",
                     wc_big, ovf_big, unf_big, fd_big, if_big.pipe_data, if_big.pipe_ready);
            n_fail++;
        end
        n_checks++;
        if ({wc_small, ovf_small, unf_small, fd_small, if_small.pipe_data, if_small.pipe_ready} !== '0) begin
            $display("FAIL reset_small: got count=%0d ovf=%b unf=%b drop=%0d data=%h ready=%b, want all zero",
                     wc_small, ovf_small, unf_small, fd_small, if_small.pipe_data, if_small.pipe_ready);
            n_fail++;
        end
        reset_global = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [15:0] d;
        logic        found;
        do_clear();
        push_model(32'h3F800000, 32'h42A00000);
        start_frame(32'h3F800000, 32'h42A00000, 10);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (wc_big == 11'd4) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1) begin
            $display("FAIL single_count: count=%0d after 8 cycles, want 4", wc_big);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            read_big(d);
            n_checks++;
            if (d !== exp_q[0]) begin
                $display("FAIL single_data%0d: got %h want %h", i, d, exp_q[0]);
                n_fail++;
            end
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (wc_big !== 11'd0) begin
            $display("FAIL single_empty: count=%0d want 0", wc_big);
            n_fail++;
        end
    endtask

    task automatic test_block_threshold();
        logic [31:0] c0, c1;
        logic [15:0] d;
        logic        found;
        int          bad;
        do_clear();
        for (int i = 0; i < 63; i++) begin
            c0 = $urandom;
            c1 = $urandom;
            push_model(c0, c1);
            send_frame(c0, c1);
        end
        n_checks++;
        if (wc_big !== 11'd252 || if_big.pipe_ready !== 1'b0) begin
            $display("FAIL block_252: count=%0d ready=%b want 252/0", wc_big, if_big.pipe_ready);
            n_fail++;
        end
        c0 = $urandom;
        c1 = $urandom;
        push_model(c0, c1);
        start_frame(c0, c1, 10);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (wc_big == 11'd256) found = 1'b1;
        end
        n_checks++;
        if (found !== 1'b1 || if_big.pipe_ready !== 1'b0) begin
            $display("FAIL block_reach: reached=%b ready=%b, want 1/0 in the cycle count hits 256",
                     found, if_big.pipe_ready);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (if_big.pipe_ready !== 1'b1) begin
            $display("FAIL block_ready: ready=%b one cycle after 256, want 1", if_big.pipe_ready);
            n_fail++;
        end
        read_big(d);
        n_checks++;
        if (d !== exp_q[0] || wc_big !== 11'd255 || if_big.pipe_ready !== 1'b1) begin
            $display("FAIL block_read: data=%h count=%0d ready=%b want %h/255/1",
                     d, wc_big, if_big.pipe_ready, exp_q[0]);
            n_fail++;
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        n_checks++;
        if (if_big.pipe_ready !== 1'b0) begin
            $display("FAIL block_unready: ready=%b after dropping to 255, want 0", if_big.pipe_ready);
            n_fail++;
        end
        bad = 0;
        while (exp_q.size() > 0) begin
            read_big(d);
            if (d !== exp_q[0]) begin
                if (bad == 0) $display("FAIL block_drain: got %h want %h with %0d left", d, exp_q[0], exp_q.size());
                bad++;
            end
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (bad != 0 || wc_big !== 11'd0) begin
            $display("FAIL block_drain_total: %0d bad words, count=%0d want 0", bad, wc_big);
            n_fail++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] c0, c1;
        logic [15:0] d;
        int          bad;
        do_clear();
        // Advance both pointers so the next 16 words wrap the 16-word array.
        c0 = $urandom;
        c1 = $urandom;
        push_model(c0, c1);
        send_frame(c0, c1);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            read_small(d);
            if (d !== exp_q[0]) bad++;
            void'(exp_q.pop_front());
        end
        for (int f = 0; f < 5; f++) begin
            c0 = $urandom;
            c1 = $urandom;
            if (f < 4) push_model(c0, c1);
            send_frame(c0, c1);
        end
        n_checks++;
        if (wc_small !== 5'd16 || ovf_small !== 1'b1 || fd_small !== 16'd1) begin
            $display("FAIL ovf_status: count=%0d ovf=%b drop=%0d want 16/1/1", wc_small, ovf_small, fd_small);
            n_fail++;
        end
        n_checks++;
        if (if_small.pipe_ready !== 1'b1) begin
            $display("FAIL ovf_ready: ready=%b with 16 words, want 1", if_small.pipe_ready);
            n_fail++;
        end
        while (exp_q.size() > 0) begin
            read_small(d);
            if (d !== exp_q[0]) begin
                $display("FAIL ovf_data: got %h want %h with %0d left", d, exp_q[0], exp_q.size());
                bad++;
            end
            void'(exp_q.pop_front());
        end
        n_checks++;
        if (bad != 0 || wc_small !== 5'd0) begin
            $display("FAIL ovf_drain: %0d bad words, count=%0d want 0", bad, wc_small);
            n_fail++;
        end
    endtask

    task automatic test_underflow_traffic();
        logic [15:0] d;
        logic        done;
        logic        pend;
        logic        timed_out;
        int          bad_data;
        int          bad_step;
        int          prev;
        do_clear();
        read_small(d);
        n_checks++;
        if (d !== 16'h0000 || unf_small !== 1'b1 || wc_small !== 5'd0) begin
            $display("FAIL unf_empty: data=%h unf=%b count=%0d want 0000/1/0", d, unf_small, wc_small);
            n_fail++;
        end
        do_clear();
        done      = 1'b0;
        pend      = 1'b0;
        timed_out = 1'b1;
        bad_data  = 0;
        bad_step  = 0;
        fork
            begin
                logic [31:0] c0, c1;
                for (int f = 0; f < 12; f++) begin
                    c0 = $urandom;
                    c1 = $urandom;
                    push_model(c0, c1);
                    start_frame(c0, c1, $urandom_range(8, 14));
                    repeat ($urandom_range(8, 14)) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                prev = 0;
                for (int cyc = 0; cyc < 3000; cyc++) begin
                    @(negedge clk);
                    if (pend) begin
                        if (exp_q.size() == 0 || if_small.pipe_data !== exp_q[0]) begin
                            if (bad_data == 0) $display("FAIL traffic_data: got %h, model has %0d words",
                                                        if_small.pipe_data, exp_q.size());
                            bad_data++;
                        end
                        if (exp_q.size() > 0) void'(exp_q.pop_front());
                    end
                    if (int'(wc_small) > prev + 1 || prev > int'(wc_small) + 1) bad_step++;
                    prev = int'(wc_small);
                    if (done && exp_q.size() == 0 && wc_small == 5'd0) begin
                        if_small.pipe_read = 1'b0;
                        timed_out = 1'b0;
                        break;
                    end
                    if_small.pipe_read = (wc_small != 5'd0) && ($urandom_range(0, 1) == 1);
                    pend = if_small.pipe_read;
                end
                if_small.pipe_read = 1'b0;
            end
        join
        n_checks++;
        if (timed_out || bad_data != 0) begin
            $display("FAIL traffic_order: timeout=%b bad_words=%0d left=%0d want 0/0/0",
                     timed_out, bad_data, exp_q.size());
            n_fail++;
        end
        n_checks++;
        if (bad_step != 0) begin
            $display("FAIL traffic_count_step: %0d jumps larger than one word, want 0", bad_step);
            n_fail++;
        end
        n_checks++;
        if (unf_small !== 1'b0 || ovf_small !== 1'b0) begin
            $display("FAIL traffic_status: unf=%b ovf=%b want 0/0", unf_small, ovf_small);
            n_fail++;
        end
    endtask

    task automatic test_enable_clear_reset();
        logic [31:0] c0, c1;
        logic [15:0] d;
        logic        found;
        do_clear();
        enable = 1'b0;
        send_frame($urandom, $urandom);
        send_frame($urandom, $urandom);
        n_checks++;
        if (wc_big !== 11'd0 || wc_small !== 5'd0 || fd_big !== 16'd0 || ovf_big !== 1'b0) begin
            $display("FAIL enable_off: count=%0d/%0d drop=%0d ovf=%b want 0/0/0/0",
                     wc_big, wc_small, fd_big, ovf_big);
            n_fail++;
        end
        enable = 1'b1;

        // One word is in, so the writer is in its second word state.
        start_frame($urandom, $urandom, 10);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (wc_big == 11'd1) found = 1'b1;
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (found !== 1'b1 || wc_big !== 11'd0) begin
            $display("FAIL clear_now: saw_w1=%b count=%0d want 1/0", found, wc_big);
            n_fail++;
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (wc_big !== 11'd0 || wc_small !== 5'd0) begin
            $display("FAIL clear_partial: count=%0d/%0d want 0/0", wc_big, wc_small);
            n_fail++;
        end
        repeat (10) @(negedge clk);

        start_frame($urandom, $urandom, 10);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (wc_big == 11'd2) found = 1'b1;
        end
        #1 reset_global = 1'b1;
        #1;
        n_checks++;
        if (found !== 1'b1 ||
            {wc_big, ovf_big, unf_big, fd_big, if_big.pipe_data, if_big.pipe_ready} !== '0) begin
            $display("FAIL reset_mid: saw_w2=%b count=%0d ovf=%b unf=%b drop=%0d data=%h ready=%b want 1/all zero",
                     found, wc_big, ovf_big, unf_big, fd_big, if_big.pipe_data, if_big.pipe_ready);
            n_fail++;
        end
        @(negedge clk);
        reset_global = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.delete();
        c0 = $urandom;
        c1 = $urandom;
        push_model(c0, c1);
        send_frame(c0, c1);
        n_checks++;
        if (wc_big !== 11'd4) begin
            $display("FAIL reset_recapture_count: count=%0d want 4", wc_big);
            n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            read_big(d);
            n_checks++;
            if (d !== exp_q[0]) begin
                $display("FAIL reset_recapture_data%0d: got %h want %h", i, d, exp_q[0]);
                n_fail++;
            end
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_block_threshold();
        test_overflow();
        test_underflow_traffic();
        test_enable_clear_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
